// File: rtl/nbody_step_sequencer.sv
// Timestep scheduler for the n-body engine: streams (i,j) pairs, then position-update sweeps.
// Build option: define SKIP_SELF_EN to drop diagonal (i==j) pairs at issue.
module nbody_step_sequencer #(
  parameter int unsigned BODIES   = 512,
  parameter int unsigned IDX_W    = $clog2(BODIES),
  parameter int unsigned ACCL_LAT = 86,
  parameter int unsigned POS_LAT  = 20,
  parameter int unsigned ITER_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [IDX_W:0]    i_num_bodies,
  input  logic [ITER_W-1:0] i_iterations,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pair_valid,
  output logic [IDX_W-1:0]  o_pair_i,
  output logic [IDX_W-1:0]  o_pair_j,
  output logic              o_pair_self,
  output logic              o_ret_valid,
  output logic [IDX_W-1:0]  o_ret_i,
  output logic              o_ret_first,
  output logic              o_ret_last,
  output logic              o_pos_valid,
  output logic [IDX_W-1:0]  o_pos_idx,
  output logic              o_pos_wr_valid,
  output logic [IDX_W-1:0]  o_pos_wr_idx,
  output logic [ITER_W-1:0] o_iter_count
);

  localparam int unsigned NW      = IDX_W + 1;
  localparam int unsigned CNT_MAX = (ACCL_LAT > POS_LAT) ? ACCL_LAT : POS_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  ACCL_END = CNT_W'(ACCL_LAT - 1);
  localparam logic [CNT_W-1:0]  POS_END  = CNT_W'(POS_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [NW-1:0]     N_MAX    = NW'(BODIES);
  localparam logic [NW-1:0]     N_ONE    = NW'(1);
  localparam logic [ITER_W-1:0] IT_ONE   = ITER_W'(1);
`ifdef SKIP_SELF_EN
  localparam logic [IDX_W-1:0]  J_START  = IDX_ONE;
`else
  localparam logic [IDX_W-1:0]  J_START  = '0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StAccel,
    StAccelDrain,
    StPos,
    StPosDrain
  } state_e;

  state_e            r_state, w_state_d;
  logic [NW-1:0]     r_n, w_n_d, w_n_new;
  logic [ITER_W-1:0] r_it, w_it_d, w_it_new, r_iter, w_iter_d, w_iter_inc;
  logic [IDX_W-1:0]  r_i, w_i_d, r_j, w_j_d, r_pos, w_pos_d;
  logic [IDX_W-1:0]  w_n_m1, w_first_j, w_last_j, w_j_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_done, w_done_d;
  logic              w_abort, w_flush, w_accel_skip, w_new_skip;
  logic              w_pair_valid, w_pair_first, w_pair_last;

  always_comb begin
    w_n_m1     = r_n[IDX_W-1:0] - IDX_ONE;
    w_n_new    = (i_num_bodies > N_MAX) ? N_MAX : i_num_bodies;
    w_it_new   = (i_iterations == '0) ? IT_ONE : i_iterations;
    w_iter_inc = r_iter + IT_ONE;
`ifdef SKIP_SELF_EN
    w_first_j    = (r_i == '0) ? IDX_ONE : '0;
    w_last_j     = (r_i == w_n_m1) ? (w_n_m1 - IDX_ONE) : w_n_m1;
    w_j_next     = ((r_j + IDX_ONE) == r_i) ? (r_j + IDX_ONE + IDX_ONE) : (r_j + IDX_ONE);
    w_accel_skip = (r_n == N_ONE);
    w_new_skip   = (w_n_new == N_ONE);
`else
    w_first_j    = '0;
    w_last_j     = w_n_m1;
    w_j_next     = r_j + IDX_ONE;
    w_accel_skip = 1'b0;
    w_new_skip   = 1'b0;
`endif
  end

  assign w_abort      = i_abort && (r_state != StIdle);
  assign w_pair_valid = (r_state == StAccel);
  assign w_pair_first = (r_j == w_first_j);
  assign w_pair_last  = (r_j == w_last_j);

  always_comb begin
    w_state_d = r_state;
    w_n_d     = r_n;
    w_it_d    = r_it;
    w_iter_d  = r_iter;
    w_i_d     = r_i;
    w_j_d     = r_j;
    w_pos_d   = r_pos;
    w_cnt_d   = r_cnt;
    w_done_d  = r_done;
    w_flush   = 1'b0;
    if (w_abort) begin
      w_state_d = StIdle;
      w_i_d     = '0;
      w_j_d     = '0;
      w_pos_d   = '0;
      w_cnt_d   = '0;
      w_flush   = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            if (i_num_bodies == '0) begin
              w_done_d = 1'b1;
            end else begin
              w_n_d     = w_n_new;
              w_it_d    = w_it_new;
              w_iter_d  = '0;
              w_done_d  = 1'b0;
              w_i_d     = '0;
              w_j_d     = J_START;
              w_cnt_d   = '0;
              w_state_d = w_new_skip ? StAccelDrain : StAccel;
            end
          end
        end
        StAccel: begin
          if (w_pair_last) begin
            if (r_i == w_n_m1) begin
              w_state_d = StAccelDrain;
              w_cnt_d   = '0;
              w_i_d     = '0;
              w_j_d     = J_START;
            end else begin
              w_i_d = r_i + IDX_ONE;
              w_j_d = '0;
            end
          end else begin
            w_j_d = w_j_next;
          end
        end
        StAccelDrain: begin
          if (r_cnt == ACCL_END) begin
            w_state_d = StPos;
            w_cnt_d   = '0;
            w_pos_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CNT_ONE;
          end
        end
        StPos: begin
          if (r_pos == w_n_m1) begin
            w_state_d = StPosDrain;
            w_cnt_d   = '0;
            w_pos_d   = '0;
          end else begin
            w_pos_d = r_pos + IDX_ONE;
          end
        end
        StPosDrain: begin
          if (r_cnt == POS_END) begin
            w_iter_d = w_iter_inc;
            w_cnt_d  = '0;
            if (w_iter_inc == r_it) begin
              w_state_d = StIdle;
              w_done_d  = 1'b1;
            end else begin
              w_state_d = w_accel_skip ? StAccelDrain : StAccel;
            end
          end else begin
            w_cnt_d = r_cnt + CNT_ONE;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_n     <= '0;
      r_it    <= '0;
      r_iter  <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_pos   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_n     <= w_n_d;
      r_it    <= w_it_d;
      r_iter  <= w_iter_d;
      r_i     <= w_i_d;
      r_j     <= w_j_d;
      r_pos   <= w_pos_d;
      r_cnt   <= w_cnt_d;
      r_done  <= w_done_d;
    end
  end

  // Tag delay lines shift every cycle; abort kills only the valid bits in flight.
  logic [ACCL_LAT-1:0] r_accl_v;
  logic [IDX_W+1:0]    r_accl_tag [ACCL_LAT];
  logic [POS_LAT-1:0]  r_pos_v;
  logic [IDX_W-1:0]    r_pos_tag  [POS_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accl_v <= '0;
      r_pos_v  <= '0;
      for (int k = 0; k < ACCL_LAT; k++) r_accl_tag[k] <= '0;
      for (int k = 0; k < POS_LAT; k++) r_pos_tag[k] <= '0;
    end else begin
      r_accl_v[0]   <= w_pair_valid & ~w_flush;
      r_accl_tag[0] <= {w_pair_first, w_pair_last, r_i};
      for (int k = 1; k < ACCL_LAT; k++) begin
        r_accl_v[k]   <= r_accl_v[k-1] & ~w_flush;
        r_accl_tag[k] <= r_accl_tag[k-1];
      end
      r_pos_v[0]   <= (r_state == StPos) & ~w_flush;
      r_pos_tag[0] <= r_pos;
      for (int k = 1; k < POS_LAT; k++) begin
        r_pos_v[k]   <= r_pos_v[k-1] & ~w_flush;
        r_pos_tag[k] <= r_pos_tag[k-1];
      end
    end
  end

  assign o_busy       = (r_state != StIdle);
  assign o_done       = r_done;
  assign o_pair_valid = w_pair_valid;
  assign o_pair_i     = r_i;
  assign o_pair_j     = r_j;
`ifdef SKIP_SELF_EN
  assign o_pair_self  = 1'b0;
`else
  assign o_pair_self  = w_pair_valid && (r_i == r_j);
`endif
  assign o_ret_valid  = r_accl_v[ACCL_LAT-1];
  assign {o_ret_first, o_ret_last, o_ret_i} = r_accl_tag[ACCL_LAT-1];
  assign o_pos_valid    = (r_state == StPos);
  assign o_pos_idx      = r_pos;
  assign o_pos_wr_valid = r_pos_v[POS_LAT-1];
  assign o_pos_wr_idx   = r_pos_tag[POS_LAT-1];
  assign o_iter_count   = r_iter;

endmodule

// File: tb/tb_nbody_step_sequencer.sv
// Directed self-checking bench for nbody_step_sequencer; follows SKIP_SELF_EN if defined.
module tb_nbody_step_sequencer;
  localparam int IDX_W    = 9;
  localparam int ACCL_LAT = 86;
  localparam int POS_LAT  = 20;
  localparam int ITER_W   = 16;
`ifdef SKIP_SELF_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, i_start = 1'b0, i_abort = 1'b0;
  logic [IDX_W:0]    i_num_bodies = '0;
  logic [ITER_W-1:0] i_iterations = '0;
  logic o_busy, o_done, o_pair_valid, o_pair_self, o_ret_valid, o_ret_first, o_ret_last;
  logic o_pos_valid, o_pos_wr_valid;
  logic [IDX_W-1:0] o_pair_i, o_pair_j, o_ret_i, o_pos_idx, o_pos_wr_idx;
  logic [ITER_W-1:0] o_iter_count;
  logic [69:0] all_out;
  int n_cmp = 0, n_err = 0;

  nbody_step_sequencer dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_num_bodies(i_num_bodies), .i_iterations(i_iterations),
    .o_busy(o_busy), .o_done(o_done), .o_pair_valid(o_pair_valid),
    .o_pair_i(o_pair_i), .o_pair_j(o_pair_j), .o_pair_self(o_pair_self),
    .o_ret_valid(o_ret_valid), .o_ret_i(o_ret_i), .o_ret_first(o_ret_first),
    .o_ret_last(o_ret_last), .o_pos_valid(o_pos_valid), .o_pos_idx(o_pos_idx),
    .o_pos_wr_valid(o_pos_wr_valid), .o_pos_wr_idx(o_pos_wr_idx),
    .o_iter_count(o_iter_count)
  );

  assign all_out = {o_busy, o_done, o_pair_valid, o_pair_i, o_pair_j, o_pair_self, o_ret_valid,
                    o_ret_i, o_ret_first, o_ret_last, o_pos_valid, o_pos_idx, o_pos_wr_valid,
                    o_pos_wr_idx, o_iter_count};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller sits in cycle 0; returns in cycle 1.
  task automatic start_run(input int nb, input int it);
    i_num_bodies = (IDX_W+1)'(nb);
    i_iterations = ITER_W'(it);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    step(); step();
    rst = 1'b0;
    step();
    n_cmp++;
    if ({o_busy, o_done, o_ret_valid} !== 3'b000) begin
      n_err++; $display("FAIL reset_idle got=%b exp=000", {o_busy, o_done, o_ret_valid});
    end
  endtask

  task automatic test_single_step();
    int np, rl, ps, dc, k;
    int ei[9];
    int ej[9];
    logic [5:0] ctl, exp_ctl;
`ifdef SKIP_SELF_EN
    ei = '{0, 0, 1, 1, 2, 2, 0, 0, 0};
    ej = '{1, 2, 0, 2, 0, 1, 0, 0, 0};
    np = 6; rl = 2;
`else
    for (int q = 0; q < 9; q++) begin
      ei[q] = q / 3; ej[q] = q % 3;
    end
    np = 9; rl = 3;
`endif
    ps = 1 + np + ACCL_LAT;
    dc = ps + 3 + POS_LAT;
    start_run(3, 1);
    for (int c = 1; c <= dc + 5; c++) begin
      exp_ctl = {c < dc, c >= dc, c <= np, (c >= 1 + ACCL_LAT) && (c < 1 + ACCL_LAT + np),
                 (c >= ps) && (c < ps + 3), (c >= ps + POS_LAT) && (c < ps + POS_LAT + 3)};
      ctl = {o_busy, o_done, o_pair_valid, o_ret_valid, o_pos_valid, o_pos_wr_valid};
      n_cmp++;
      if (ctl !== exp_ctl) begin
        n_err++; $display("FAIL single_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl);
      end
      if (c <= np) begin
        k = c - 1;
        n_cmp++;
        if ({o_pair_i, o_pair_j, o_pair_self} !==
            {IDX_W'(ei[k]), IDX_W'(ej[k]), (ei[k] == ej[k]) && !SKIP}) begin
          n_err++; $display("FAIL single_pair c=%0d got=(%0d,%0d,%b) exp=(%0d,%0d)",
                            c, o_pair_i, o_pair_j, o_pair_self, ei[k], ej[k]);
        end
      end
      if ((c >= 1 + ACCL_LAT) && (c < 1 + ACCL_LAT + np)) begin
        k = c - 1 - ACCL_LAT;
        n_cmp++;
        if ({o_ret_i, o_ret_first, o_ret_last} !==
            {IDX_W'(ei[k]), (k % rl) == 0, (k % rl) == rl - 1}) begin
          n_err++; $display("FAIL single_ret c=%0d got=(%0d,%b,%b) exp_i=%0d",
                            c, o_ret_i, o_ret_first, o_ret_last, ei[k]);
        end
      end
      if ((c >= ps) && (c < ps + 3)) begin
        n_cmp++;
        if (o_pos_idx !== IDX_W'(c - ps)) begin
          n_err++; $display("FAIL single_pos c=%0d got=%0d exp=%0d", c, o_pos_idx, c - ps);
        end
      end
      if ((c >= ps + POS_LAT) && (c < ps + POS_LAT + 3)) begin
        n_cmp++;
        if (o_pos_wr_idx !== IDX_W'(c - ps - POS_LAT)) begin
          n_err++; $display("FAIL single_poswr c=%0d got=%0d exp=%0d", c, o_pos_wr_idx,
                            c - ps - POS_LAT);
        end
      end
      if (c == dc) begin
        n_cmp++;
        if (o_iter_count !== ITER_W'(1)) begin
          n_err++; $display("FAIL single_iter got=%0d exp=1", o_iter_count);
        end
      end
      // A start pulse mid-run with other parameters must be ignored.
      i_start = (c == 5);
      if (c == 5) begin
        i_num_bodies = 5; i_iterations = 4;
      end
      step();
    end
    i_start = 1'b0;
  endtask

  task automatic test_multi_step();
    int np, per, dc, off, ei, ej, exp_it;
    logic [3:0] ctl, exp_ctl;
    np = SKIP ? 2 : 4;
    per = np + 2 + ACCL_LAT + POS_LAT;
    dc = 1 + 3 * per;
    start_run(2, 3);
    for (int c = 1; c <= dc + 2; c++) begin
      off = (c - 1) % per;
      exp_ctl = {c < dc, c >= dc, (c < dc) && (off < np),
                 (c < dc) && (off >= np + ACCL_LAT) && (off < np + ACCL_LAT + 2)};
      ctl = {o_busy, o_done, o_pair_valid, o_pos_valid};
      n_cmp++;
      if (ctl !== exp_ctl) begin
        n_err++; $display("FAIL multi_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl);
      end
      exp_it = (c >= dc) ? 3 : (c - 1) / per;
      n_cmp++;
      if (o_iter_count !== ITER_W'(exp_it)) begin
        n_err++; $display("FAIL multi_iter c=%0d got=%0d exp=%0d", c, o_iter_count, exp_it);
      end
      if ((c < dc) && (off < np)) begin
        ei = SKIP ? off : off / 2;
        ej = SKIP ? 1 - off : off % 2;
        n_cmp++;
        if ({o_pair_i, o_pair_j} !== {IDX_W'(ei), IDX_W'(ej)}) begin
          n_err++; $display("FAIL multi_pair c=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                            c, o_pair_i, o_pair_j, ei, ej);
        end
      end
      step();
    end
  endtask

  task automatic test_edge_counts();
    int rl, dn;
    logic [2:0] ctl, exp_ctl;
    rst = 1'b1; step(); rst = 1'b0;
    start_run(0, 5);
    for (int c = 1; c <= 3; c++) begin
      ctl = {o_busy, o_done, o_pair_valid};
      n_cmp++;
      if (ctl !== 3'b010) begin
        n_err++; $display("FAIL zero_bodies c=%0d got=%b exp=010", c, ctl);
      end
      step();
    end
    // 600 bodies clamps to 512: row 0 ends at j=511, then wraps to (1,0).
    rl = SKIP ? 511 : 512;
    start_run(600, 1);
    for (int c = 1; c <= rl + 1; c++) begin
      if (c == 1) begin
        n_cmp++;
        if ({o_pair_valid, o_pair_i, o_pair_j, o_pair_self} !==
            {1'b1, IDX_W'(0), IDX_W'(SKIP ? 1 : 0), !SKIP}) begin
          n_err++; $display("FAIL clamp_first got=(%b,%0d,%0d,%b)", o_pair_valid, o_pair_i,
                            o_pair_j, o_pair_self);
        end
      end
      if (c == rl) begin
        n_cmp++;
        if ({o_pair_valid, o_pair_i, o_pair_j} !== {1'b1, IDX_W'(0), IDX_W'(511)}) begin
          n_err++; $display("FAIL clamp_row_end got=(%b,%0d,%0d) exp=(1,0,511)",
                            o_pair_valid, o_pair_i, o_pair_j);
        end
      end
      if (c == rl + 1) begin
        n_cmp++;
        if ({o_pair_valid, o_pair_i, o_pair_j} !== {1'b1, IDX_W'(1), IDX_W'(0)}) begin
          n_err++; $display("FAIL clamp_wrap got=(%b,%0d,%0d) exp=(1,1,0)",
                            o_pair_valid, o_pair_i, o_pair_j);
        end
      end
      step();
    end
    i_abort = 1'b1; step(); i_abort = 1'b0;
    n_cmp++;
    if ({o_busy, o_done} !== 2'b00) begin
      n_err++; $display("FAIL clamp_abort got=%b exp=00", {o_busy, o_done});
    end
    // iterations=0 runs one timestep.
    dn = SKIP ? 2 + ACCL_LAT + POS_LAT : 3 + ACCL_LAT + POS_LAT;
    start_run(1, 0);
    for (int c = 1; c <= dn; c++) begin
      exp_ctl = {c < dn, c >= dn, !SKIP && (c == 1)};
      ctl = {o_busy, o_done, o_pair_valid};
      n_cmp++;
      if (ctl !== exp_ctl) begin
        n_err++; $display("FAIL iter0_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl);
      end
      if (c == dn) begin
        n_cmp++;
        if (o_iter_count !== ITER_W'(1)) begin
          n_err++; $display("FAIL iter0_count got=%0d exp=1", o_iter_count);
        end
      end
      step();
    end
  endtask

  task automatic test_abort();
    int np, dc;
    logic [4:0] ctl;
    logic [2:0] c3, e3;
    start_run(3, 1);
    for (int c = 1; c < 50; c++) step();
    i_abort = 1'b1; step(); i_abort = 1'b0;
    for (int c = 51; c <= 150; c++) begin
      ctl = {o_busy, o_done, o_ret_valid, o_pos_valid, o_pos_wr_valid};
      n_cmp++;
      if (ctl !== 5'b00000) begin
        n_err++; $display("FAIL abort_quiet c=%0d got=%b exp=00000", c, ctl);
      end
      step();
    end
    np = SKIP ? 2 : 4;
    dc = 1 + np + 2 + ACCL_LAT + POS_LAT;
    start_run(2, 1);
    for (int c = 1; c <= dc; c++) begin
      e3 = {c < dc, c >= dc, (c >= 1 + ACCL_LAT) && (c < 1 + ACCL_LAT + np)};
      c3 = {o_busy, o_done, o_ret_valid};
      n_cmp++;
      if (c3 !== e3) begin
        n_err++; $display("FAIL abort_rerun c=%0d got=%b exp=%b", c, c3, e3);
      end
      step();
    end
  endtask

  task automatic test_start_abort();
    start_run(2, 2);
    for (int c = 1; c < 20; c++) step();
    i_num_bodies = 3; i_start = 1'b1; i_abort = 1'b1;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    n_cmp++;
    if ({o_busy, o_done} !== 2'b00) begin
      n_err++; $display("FAIL start_abort_c21 got=%b exp=00", {o_busy, o_done});
    end
    step();
    n_cmp++;
    if ({o_busy, o_done, o_pair_valid} !== 3'b000) begin
      n_err++; $display("FAIL start_abort_c22 got=%b exp=000", {o_busy, o_done, o_pair_valid});
    end
  endtask

  task automatic test_reset_midrun();
    start_run(3, 1);
    for (int c = 1; c < 90; c++) step();
    n_cmp++;
    if ({o_busy, o_ret_valid} !== 2'b11) begin
      n_err++; $display("FAIL midrun_pre got=%b exp=11", {o_busy, o_ret_valid});
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL midrun_reset got=%h exp=0", all_out);
    end
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if ({o_busy, o_done, o_ret_valid} !== 3'b000) begin
      n_err++; $display("FAIL midrun_after got=%b exp=000", {o_busy, o_done, o_ret_valid});
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_multi_step();
    test_edge_counts();
    test_abort();
    test_start_abort();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nbody_step_sequencer.md
Name: nbody_step_sequencer

Overview:
Central scheduler for one or more simulation timesteps of the n-body engine. Per timestep it runs two phases:
- Acceleration phase: streams (i,j) body-index pairs into the pipelined acceleration unit, one per cycle, and re-times each issue tag by the pipeline latency so the accumulate/write-back logic knows which result is which.
- Position-update phase: sweeps body indices through the position/velocity update path.

It sits between the bus-facing register block (start, body count, iteration count) and the RAM address muxes and datapath enables.

Parameters:
BODIES, 512, maximum body count (RAM depth)
IDX_W, $clog2(BODIES), body index width
ACCL_LAT, 86, acceleration pipeline latency in cycles (issue to result)
POS_LAT, 20, position-update pipeline latency in cycles (read to write-back)
ITER_W, 16, iteration counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin a run; ignored while busy
abort  in  1  synchronous cancel of a run in progress
num_bodies  in  IDX_W+1  body count, sampled on accepted start
iterations  in  ITER_W  timesteps to run, sampled on accepted start
busy  out  1  high from the cycle after accepted start until done
done  out  1  level; set at run completion, cleared by next accepted start
pair_valid  out  1  pair issue strobe to the acceleration unit
pair_i  out  IDX_W  i body read address
pair_j  out  IDX_W  j body read address
pair_self  out  1  pair_i==pair_j; contribution is masked downstream
ret_valid  out  1  pair_valid delayed by ACCL_LAT
ret_i  out  IDX_W  pair_i delayed by ACCL_LAT
ret_first  out  1  first pair of body i, delayed by ACCL_LAT; clears the accumulator
ret_last  out  1  last pair of body i, delayed by ACCL_LAT; commits the accumulator
pos_valid  out  1  position-update read strobe
pos_idx  out  IDX_W  position-update read address
pos_wr_valid  out  1  pos_valid delayed by POS_LAT; write enable
pos_wr_idx  out  IDX_W  pos_idx delayed by POS_LAT; write address
iter_count  out  ITER_W  number of completed timesteps in the current run

Behaviour:
Reset:
- All outputs are 0, state is IDLE, and every delay-line valid bit is cleared.

States: IDLE, ACCEL, ACCEL_DRAIN, POS, POS_DRAIN.

IDLE:
- start=1 with num_bodies>=1: latch n=min(num_bodies,BODIES) and it=max(iterations,1); clear done and iter_count; set busy; go to ACCEL.
- start=1 with num_bodies==0: set done=1 next cycle; no issue; stay in IDLE.

ACCEL:
- Issues one pair per cycle in row-major order: i=0..n-1, and j=0..n-1 within each i.
- ret_first is tagged when j is the first j issued for i; ret_last when j is the last j issued for i.
- Moves to ACCEL_DRAIN in the cycle after the pair (n-1,n-1) is issued.

ACCEL_DRAIN:
- Lasts exactly ACCL_LAT cycles, so the final ret_valid occurs in the last drain cycle.
- Then go to POS.

POS:
- Issues pos_idx=0..n-1, one per cycle.
- Then POS_DRAIN for exactly POS_LAT cycles.

End of POS_DRAIN:
- iter_count increments.
- If iter_count has reached it: busy=0, done=1, go to IDLE.
- Otherwise: go to ACCEL with i=j=0.

Timing, with accepted start at cycle 0:
- First pair is issued at cycle 1.
- Timestep period is n²+n+ACCL_LAT+POS_LAT cycles.
- done and busy=0 take effect at cycle 1+it·period.

Delay lines:
- Fixed-length shift registers carrying valid plus tags.
- They operate every cycle regardless of state.

Other rules:
- start while busy is ignored, with no effect on the latched n or it.
- abort (in any state other than IDLE): next cycle state=IDLE, busy=0, done stays 0, and every delay-line valid bit is cleared so no ret_valid or pos_wr_valid follows.
- abort and start in the same cycle: abort wins.
- Reset mid-run: outputs return to their reset values immediately (asynchronous).
- Index counters never exceed n-1; n=BODIES wraps cleanly within IDX_W bits.

Optional Feature:
Macro: SKIP_SELF_EN
- Defined:
  - Pairs with i==j are not issued; j steps over i, and pair_self is tied to 0.
  - Issue count per timestep is n(n-1); the period becomes n(n-1)+n+ACCL_LAT+POS_LAT.
  - ret_first and ret_last follow the actually-issued j values.
  - For n=1 no pairs are issued: ACCEL is skipped, but ACCEL_DRAIN still runs.
- Not defined: all n² pairs are issued, with pair_self flagging the diagonal.

Test Plan:
- Single step: n=3, it=1, defaults, start at cycle 0 -> pairs (0,0)..(2,2) on cycles 1-9; ret_valid on cycles 87-95 with ret_first at 87/90/93 and ret_last at 89/92/95; pos_idx 0,1,2 on cycles 96-98; pos_wr on 116-118; done=1 at cycle 119.
- Multi-step: n=2, it=3 -> done at cycle 1+3·112=337; iter_count reads 1, 2, 3 after each timestep; no issue gaps apart from drains.
- Edge counts: num_bodies=0 -> done without busy; num_bodies=600 -> clamped to 512, last pair (511,511); iterations=0 -> behaves as 1.
- Abort during ACCEL_DRAIN at cycle 50 (n=3) -> no ret_valid after cycle 50, busy=0 at 51, done=0; a following start runs cleanly.
- start pulses while busy, and start coincident with abort -> ignored, with no change to the run.
- SKIP_SELF_EN, n=3 -> 6 pairs (0,1),(0,2),(1,0),(1,2),(2,0),(2,1) on cycles 1-6; n=1 -> zero pairs, done at cycle 1+0+1+86+20=108.
